mmio_bridge: RTL and testbench

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_bridge.sv | 171 +++++++++++++++++
 tb/tb_mmio_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// CPU-facing MMIO bridge: RAM pass-through, UART RX read port, UART TX FIFO,
// free-running cycle counter with snapshot, and sticky finish/overflow flags.
module mmio_bridge #(
    parameter int TX_DEPTH_BIT = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_finish,
    output logic        tx_overflow
);
    localparam int              CW        = TX_DEPTH_BIT + 1;
    localparam int              DEPTH     = 1 << TX_DEPTH_BIT;
    localparam logic [CW-1:0]   DEPTH_W   = CW'(DEPTH);
    localparam logic [CW-1:0]   MARGIN_W  = CW'(FULL_MARGIN);
    localparam logic [17:0]     ADDR_UART = 18'h30000;
    localparam logic [17:0]     ADDR_CNT0 = 18'h30004;
    localparam logic [17:0]     ADDR_CNT1 = 18'h30005;
    localparam logic [17:0]     ADDR_CNT2 = 18'h30006;
    localparam logic [17:0]     ADDR_CNT3 = 18'h30007;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_RX   = 2'd2,
        SRC_CNT  = 2'd3
    } src_e;

    logic [17:0]             w_addr;
    logic                    w_is_io;
    logic                    w_rd;
    logic                    w_wr;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_accept;
    logic [CW-1:0]           w_count_next;
    logic [7:0]              w_mux;
    logic                    w_unused_addr;

    logic [31:0]             r_cnt;
    logic [31:0]             r_snap;
    src_e                    r_src;
    logic [7:0]              r_byte;
    logic [TX_DEPTH_BIT-1:0] r_head;
    logic [TX_DEPTH_BIT-1:0] r_tail;
    logic [CW-1:0]           r_count;
    logic                    r_finish;
    logic                    r_overflow;
    logic                    r_buffer_full;
    logic                    r_live;
    logic [7:0]              r_held;
    logic [7:0]              r_mem [DEPTH];

    assign w_addr        = mem_a[17:0];
    assign w_unused_addr = ^mem_a[31:18];
    assign w_is_io       = (w_addr[17:16] == 2'b11);
    assign w_rd          = rdy_in & ~mem_wr & ~rst_in;
    assign w_wr          = rdy_in &  mem_wr & ~rst_in;

    assign ram_a   = mem_a[16:0];
    assign ram_din = mem_dout;
    assign ram_wr  = w_wr & ~w_is_io;
    assign rx_pop  = w_rd & (w_addr == ADDR_UART) & rx_valid;

    // A zero byte is never queued; a full FIFO still accepts when it pops the same cycle.
    assign w_push   = w_wr & (w_addr == ADDR_UART) & (mem_dout != 8'h00);
    assign w_full   = (r_count == DEPTH_W);
    assign tx_valid = (r_count != {CW{1'b0}});
    assign w_pop    = rdy_in & tx_valid & tx_ready;
    assign w_accept = w_push & (~w_full | w_pop);
    assign tx_data  = tx_valid ? r_mem[r_head] : 8'h00;

    assign io_buffer_full = r_buffer_full;
    assign program_finish = r_finish;
    assign tx_overflow    = r_overflow;

    // Next FIFO occupancy from the accepted push and the pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Read data mux selected by the source registered in the access cycle.
    always_comb begin
        w_mux = 8'h00;
        case (r_src)
            SRC_RAM:  w_mux = ram_dout;
            SRC_ZERO: w_mux = 8'h00;
            default:  w_mux = r_byte;
        endcase
    end

    // While stalled, mem_din replays the value captured before the stall began.
    assign mem_din = r_live ? w_mux : r_held;

    // Main control state: counter, snapshot, read select, FIFO pointers and flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt         <= 32'd0;
            r_snap        <= 32'd0;
            r_src         <= SRC_ZERO;
            r_byte        <= 8'h00;
            r_head        <= {TX_DEPTH_BIT{1'b0}};
            r_tail        <= {TX_DEPTH_BIT{1'b0}};
            r_count       <= {CW{1'b0}};
            r_finish      <= 1'b0;
            r_overflow    <= 1'b0;
            r_buffer_full <= 1'b0;
        end else if (rdy_in) begin
            r_cnt         <= r_cnt + 32'd1;
            r_count       <= w_count_next;
            r_buffer_full <= ((DEPTH_W - w_count_next) <= MARGIN_W);
            if (w_accept) r_tail <= r_tail + TX_DEPTH_BIT'(1);
            if (w_pop) r_head <= r_head + TX_DEPTH_BIT'(1);
            if (w_wr && (w_addr == ADDR_CNT0)) r_finish <= 1'b1;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_rd) begin
                if (!w_is_io) begin
                    r_src  <= SRC_RAM;
                    r_byte <= 8'h00;
                end else begin
                    case (w_addr)
                        ADDR_UART: begin r_src <= SRC_RX;  r_byte <= rx_valid ? rx_data : 8'h00; end
                        ADDR_CNT0: begin r_src <= SRC_CNT; r_snap <= r_cnt; r_byte <= r_cnt[7:0]; end
                        ADDR_CNT1: begin r_src <= SRC_CNT; r_byte <= r_snap[15:8];  end
                        ADDR_CNT2: begin r_src <= SRC_CNT; r_byte <= r_snap[23:16]; end
                        ADDR_CNT3: begin r_src <= SRC_CNT; r_byte <= r_snap[31:24]; end
                        default:   begin r_src <= SRC_ZERO; r_byte <= 8'h00; end
                    endcase
                end
            end
        end
    end

    // Hold register for mem_din across rdy_in-low stretches.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_live <= 1'b0;
            r_held <= 8'h00;
        end else begin
            r_live <= rdy_in;
            if (r_live) r_held <= w_mux;
        end
    end

    // FIFO storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk_in) begin
        if (w_accept) r_mem[r_tail] <= mem_dout;
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios plus a randomized run
// compared against a queue/array based behavioural model.
module tb_mmio_bridge;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_finish;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic [7:0]  q[$];
    logic        m_fin;
    logic        m_ovf;
    logic [7:0]  m_din;
    logic        m_din_ok;
    logic [7:0]  ref_ram[int];
    int          wr_addrs[$];
    logic [7:0]  pop_log[$];
    logic [7:0]  env_ram [0:131071];

    mmio_bridge #(.TX_DEPTH_BIT(3), .FULL_MARGIN(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_wr(ram_wr),
        .ram_din(ram_din), .ram_dout(ram_dout), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_pop(rx_pop), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .program_finish(program_finish), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM environment: data is valid one cycle after the address.
    always @(posedge clk_in) begin
        if (ram_wr) env_ram[ram_a] <= ram_din;
        ram_dout <= env_ram[ram_a];
    end

    // Record every byte the UART takes from the FIFO.
    always @(posedge clk_in) begin
        if (!rst_in && rdy_in && tx_valid && tx_ready) pop_log.push_back(tx_data);
    end

    task automatic model_reset();
        m_cnt = 32'd0; m_snap = 32'd0; q.delete();
        m_fin = 1'b0; m_ovf = 1'b0; m_din = 8'h00; m_din_ok = 1'b1;
    endtask

    task automatic drive(input logic rdy, input logic wr, input logic [17:0] a, input logic [7:0] d);
        rdy_in = rdy; mem_wr = wr; mem_a = {14'($urandom()), a}; mem_dout = d;
    endtask

    // Advance the model by one cycle using the applied inputs, then cross the clock edge.
    task automatic step();
        logic [17:0] a;
        logic        io, pop, push, full_before;
        int          idx;
        a = mem_a[17:0]; io = (a[17:16] == 2'b11); push = 1'b0; idx = int'(a[16:0]);
        if (rdy_in) begin
            if (!mem_wr) begin
                m_din_ok = 1'b1;
                if (!io) begin
                    if (ref_ram.exists(idx)) m_din = ref_ram[idx];
                    else m_din_ok = 1'b0;
                end else if (a == 18'h30000) m_din = rx_valid ? rx_data : 8'h00;
                else if (a == 18'h30004) begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                else if (a >= 18'h30005 && a <= 18'h30007) m_din = 8'(m_snap >> (8 * (int'(a) - 32'h30004)));
                else m_din = 8'h00;
            end else begin
                m_din_ok = 1'b0;
                if (!io) ref_ram[idx] = mem_dout;
                else if (a == 18'h30000) push = (mem_dout != 8'h00);
                else if (a == 18'h30004) m_fin = 1'b1;
            end
            full_before = (q.size() == DEPTH);
            pop = (q.size() != 0) && tx_ready;
            if (pop) void'(q.pop_front());
            if (push) begin
                if (full_before && !pop) m_ovf = 1'b1;
                else q.push_back(mem_dout);
            end
            m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk_in); #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 18'h30000, 8'h00); rx_valid = 1'b1; rx_data = 8'h55;
        @(posedge clk_in); #1;
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got %h exp 00", mem_din); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_buffer_full got %b exp 0", io_buffer_full); end
        checks++; if (program_finish !== 1'b0 || tx_overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", program_finish, tx_overflow); end
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rx_pop got %b exp 0", rx_pop); end
        rx_valid = 1'b0;
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic test_ram();
        logic [17:0] a;
        logic [7:0]  d;
        drive(1'b1, 1'b1, 18'h00100, 8'h41); #1;
        checks++; if (ram_wr !== 1'b1 || ram_a !== 17'h00100 || ram_din !== 8'h41) begin errors++; $display("FAIL ram_write got wr=%b a=%h d=%h exp 1 00100 41", ram_wr, ram_a, ram_din); end
        step();
        drive(1'b1, 1'b0, 18'h00100, 8'h00); #1;
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL ram_read_wr got %b exp 0", ram_wr); end
        step();
        checks++; if (mem_din !== 8'h41) begin errors++; $display("FAIL ram_readback got %h exp 41", mem_din); end
        for (int i = 0; i < 6; i++) begin
            a = {2'($urandom_range(0, 2)), 16'($urandom())}; d = 8'($urandom());
            drive(1'b1, 1'b1, a, d); #1;
            checks++; if (ram_wr !== 1'b1 || ram_a !== a[16:0]) begin errors++; $display("FAIL ram_rand_write got wr=%b a=%h exp 1 %h", ram_wr, ram_a, a[16:0]); end
            step();
            drive(1'b1, 1'b0, a, 8'h00);
            step();
            checks++; if (mem_din !== d) begin errors++; $display("FAIL ram_rand_read got %h exp %h", mem_din, d); end
        end
    endtask

    task automatic test_tx();
        logic [7:0] seq [3] = '{8'h48, 8'h00, 8'h69};
        tx_ready = 1'b1; pop_log.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 18'h30000, seq[i]);
            step();
            if (i == 0) begin
                checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin errors++; $display("FAIL tx_first got v=%b d=%h exp 1 48", tx_valid, tx_data); end
            end
        end
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 18'h00100, 8'h00); step(); end
        checks++; if (pop_log.size() != 2) begin errors++; $display("FAIL tx_pop_count got %0d exp 2", pop_log.size()); end
        else begin
            checks++; if (pop_log[0] !== 8'h48 || pop_log[1] !== 8'h69) begin errors++; $display("FAIL tx_pop_data got %h %h exp 48 69", pop_log[0], pop_log[1]); end
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty got %b exp 0", tx_valid); end
    endtask

    task automatic test_fill();
        logic [7:0] fill [8];
        logic [7:0] extra, lost;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fill[i] = 8'($urandom_range(1, 255));
            drive(1'b1, 1'b1, 18'h30000, fill[i]);
            step();
            checks++; if (io_buffer_full !== ((DEPTH - q.size()) <= MARGIN)) begin errors++; $display("FAIL fill_buffer_full push=%0d got %b exp %b", i + 1, io_buffer_full, (DEPTH - q.size()) <= MARGIN); end
            if (i == 5) begin
                checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL fill_full_after_6 got %b exp 1", io_buffer_full); end
            end
        end
        checks++; if (tx_overflow !== 1'b0 || tx_data !== fill[0]) begin errors++; $display("FAIL fill_state got ovf=%b d=%h exp 0 %h", tx_overflow, tx_data, fill[0]); end
        extra = 8'($urandom_range(1, 255)); pop_log.delete(); tx_ready = 1'b1;
        drive(1'b1, 1'b1, 18'h30000, extra);
        step();
        checks++; if (tx_overflow !== 1'b0 || pop_log.size() != 1) begin errors++; $display("FAIL full_push_pop got ovf=%b pops=%0d exp 0 1", tx_overflow, pop_log.size()); end
        tx_ready = 1'b0; pop_log.delete(); lost = 8'($urandom_range(1, 255));
        drive(1'b1, 1'b1, 18'h30000, lost);
        step();
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b exp 1", tx_overflow); end
        checks++; if (tx_data !== fill[1]) begin errors++; $display("FAIL overflow_head got %h exp %h", tx_data, fill[1]); end
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b0, 18'h00100, 8'h00); step(); end
        checks++; if (pop_log.size() != 8) begin errors++; $display("FAIL drain_count got %0d exp 8", pop_log.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (pop_log[i] !== ((i < 7) ? fill[i + 1] : extra)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, pop_log[i], (i < 7) ? fill[i + 1] : extra); end
            end
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        rx_valid = 1'b1; rx_data = 8'h37;
        drive(1'b1, 1'b0, 18'h30000, 8'h00); #1;
        checks++; if (rx_pop !== 1'b1) begin errors++; $display("FAIL rx_pop_valid got %b exp 1", rx_pop); end
        step();
        drive(1'b1, 1'b0, 18'h30010, 8'h00); #1;
        checks++; if (mem_din !== 8'h37) begin errors++; $display("FAIL rx_data got %h exp 37", mem_din); end
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_pulse got %b exp 0", rx_pop); end
        step();
        rx_valid = 1'b0;
        drive(1'b1, 1'b0, 18'h30000, 8'h00); #1;
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_empty got %b exp 0", rx_pop); end
        step();
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_empty_data got %h exp 00", mem_din); end
    endtask

    task automatic test_counter();
        logic [7:0] exp [4] = '{8'h2C, 8'h01, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 300; i++) begin drive(1'b1, 1'b0, 18'h00100, 8'h00); step(); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 18'h30004 + 18'(i), 8'h00);
            step();
            checks++; if (mem_din !== exp[i] || mem_din !== m_din) begin errors++; $display("FAIL counter_byte%0d got %h exp %h", i, mem_din, exp[i]); end
        end
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 18'h00100, 8'h00); step(); end
        drive(1'b1, 1'b0, 18'h30005, 8'h00);
        step();
        checks++; if (mem_din !== 8'h01) begin errors++; $display("FAIL counter_no_resnap got %h exp 01", mem_din); end
    endtask

    task automatic test_stall();
        logic [7:0] c0;
        tx_ready = 1'b0;
        drive(1'b1, 1'b1, 18'h30000, 8'h11); step();
        drive(1'b1, 1'b1, 18'h30000, 8'h22); step();
        drive(1'b1, 1'b1, 18'h30004, 8'h01); step();
        checks++; if (program_finish !== 1'b1 || tx_data !== 8'h11) begin errors++; $display("FAIL finish_set got fin=%b d=%h exp 1 11", program_finish, tx_data); end
        drive(1'b1, 1'b0, 18'h30004, 8'h00); step();
        c0 = mem_din;
        checks++; if (mem_din !== m_din) begin errors++; $display("FAIL stall_snap got %h exp %h", mem_din, m_din); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), 16'h0000}, 8'h5A);
            rx_valid = 1'b1; tx_ready = 1'b1; #1;
            checks++; if (ram_wr !== 1'b0 || rx_pop !== 1'b0) begin errors++; $display("FAIL stall_strobes got wr=%b pop=%b exp 0 0", ram_wr, rx_pop); end
            step();
            checks++; if (mem_din !== c0 || tx_data !== 8'h11 || program_finish !== 1'b1) begin errors++; $display("FAIL stall_hold got din=%h d=%h fin=%b exp %h 11 1", mem_din, tx_data, program_finish, c0); end
        end
        rx_valid = 1'b0; tx_ready = 1'b0;
        drive(1'b1, 1'b0, 18'h30004, 8'h00); step();
        checks++; if (mem_din !== 8'(c0 + 8'd1) || mem_din !== m_din) begin errors++; $display("FAIL stall_frozen_cnt got %h exp %h", mem_din, 8'(c0 + 8'd1)); end
        drive(1'b1, 1'b0, 18'h30000, 8'h00); rx_valid = 1'b1; #2;
        rst_in = 1'b1; #1;
        checks++; if (mem_din !== 8'h00 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL async_rst_data got din=%h v=%b d=%h exp 00 0 00", mem_din, tx_valid, tx_data); end
        checks++; if (program_finish !== 1'b0 || tx_overflow !== 1'b0 || io_buffer_full !== 1'b0 || rx_pop !== 1'b0) begin errors++; $display("FAIL async_rst_flags got %b%b%b%b exp 0000", program_finish, tx_overflow, io_buffer_full, rx_pop); end
        rx_valid = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0; model_reset();
        drive(1'b1, 1'b0, 18'h30004, 8'h00); step();
        checks++; if (mem_din !== 8'h00 || tx_valid !== 1'b0) begin errors++; $display("FAIL post_rst got din=%h v=%b exp 00 0", mem_din, tx_valid); end
    endtask

    task automatic test_random();
        logic [17:0] a;
        logic [7:0]  d;
        logic        rdy, wr, exp_rxpop, exp_ramwr;
        int          kind;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9); d = 8'($urandom()); rdy = ($urandom_range(0, 7) != 0); wr = 1'b0;
            case (kind)
                0, 1, 2: begin a = {2'($urandom_range(0, 2)), 16'($urandom())}; wr = 1'b1; wr_addrs.push_back(int'(a[16:0])); end
                3, 4:    a = (wr_addrs.size() != 0) ? {1'b0, 17'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)])} : 18'h00100;
                5:       begin a = 18'h30000; wr = 1'b1; if ($urandom_range(0, 3) == 0) d = 8'h00; end
                6:       a = 18'h30000;
                7:       a = 18'h30004 + 18'($urandom_range(0, 3));
                8:       begin a = 18'h30004; wr = ($urandom_range(0, 9) == 0); end
                default: begin a = 18'h30008 + 18'($urandom_range(0, 255)); wr = 1'($urandom_range(0, 1)); end
            endcase
            drive(rdy, wr, a, d);
            tx_ready = ($urandom_range(0, 3) == 0); rx_valid = 1'($urandom_range(0, 1)); rx_data = 8'($urandom());
            #1;
            exp_rxpop = rdy && !wr && (a == 18'h30000) && rx_valid;
            exp_ramwr = rdy && wr && (a[17:16] != 2'b11);
            checks++; if (rx_pop !== exp_rxpop || ram_wr !== exp_ramwr) begin errors++; $display("FAIL rand_strobes cyc=%0d got pop=%b wr=%b exp %b %b", i, rx_pop, ram_wr, exp_rxpop, exp_ramwr); end
            step();
            checks++; if (tx_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_tx_valid cyc=%0d got %b exp %b", i, tx_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (tx_data !== q[0]) begin errors++; $display("FAIL rand_tx_data cyc=%0d got %h exp %h", i, tx_data, q[0]); end
            end
            checks++; if (io_buffer_full !== ((DEPTH - q.size()) <= MARGIN)) begin errors++; $display("FAIL rand_buffer_full cyc=%0d got %b exp %b", i, io_buffer_full, (DEPTH - q.size()) <= MARGIN); end
            checks++; if (tx_overflow !== m_ovf || program_finish !== m_fin) begin errors++; $display("FAIL rand_flags cyc=%0d got %b%b exp %b%b", i, tx_overflow, program_finish, m_ovf, m_fin); end
            if (m_din_ok) begin
                checks++; if (mem_din !== m_din) begin errors++; $display("FAIL rand_mem_din cyc=%0d got %h exp %h", i, mem_din, m_din); end
            end
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; mem_a = 32'd0; mem_dout = 8'h00; mem_wr = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        model_reset();
        test_reset();
        test_ram();
        test_tx();
        test_fill();
        test_rx();
        test_counter();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
